key_debounce_array: RTL and testbench
=====================================

// Module: key_debounce_array
// PURPOSE
//  Parametrised multi-channel successor to the single-key debouncer feeding camera capture.
//  Synchronises N_CH raw, asynchronous, bouncy inputs (KEY/SW) into the i_clk domain.
//  Filters each channel and emits, per channel: stable level, one-cycle rising pulse,
//  one-cycle falling pulse, and (optionally) an auto-repeat pulse while held active.
//  Sits between board pins and control logic: capture, mode select, NIOS handshake.
// PARAMETERS
//  N_CH          4           number of independent channels
//  CNT_MAX       500_000     consecutive mismatching cycles needed to accept a change (10 ms @ 50 MHz); >=1
//  IDLE_LEVEL    1'b1        reset/idle level of every channel; active level = ~IDLE_LEVEL
//  REPEAT_DELAY  25_000_000  cycles from press pulse to first repeat pulse (REPEAT_EN only); >=1
//  REPEAT_PERIOD 5_000_000   cycles between subsequent repeat pulses (REPEAT_EN only); >=1
// PORTS
//  i_clk     in   1     system clock (CLOCK_50)
//  i_rst_n   in   1     asynchronous active-low reset
//  i_in      in   N_CH  raw asynchronous inputs
//  o_level   out  N_CH  debounced stable level
//  o_pos     out  N_CH  1-cycle pulse on debounced 0->1
//  o_neg     out  N_CH  1-cycle pulse on debounced 1->0
//  o_repeat  out  N_CH  1-cycle auto-repeat pulse while held at active level
// BEHAVIOUR
//  - Reset (async assert, sync release): sync FFs and o_level = {N_CH{IDLE_LEVEL}};
//    o_pos, o_neg, o_repeat = 0; all counters = 0.
//  - Sync: 2-FF synchroniser per channel, reset to IDLE_LEVEL; s = second stage.
//  - Filter per channel, counter width $clog2(CNT_MAX+1):
//    s == o_level -> cnt <= 0.
//    s != o_level and cnt < CNT_MAX-1 -> cnt <= cnt+1.
//    s != o_level and cnt == CNT_MAX-1 -> o_level <= s; cnt <= 0; edge pulse for one cycle.
//  - Latency: raw change first sampled at edge k -> o_level and pulse update at edge k+1+CNT_MAX.
//    Pulses are registered, coincident with the o_level update.
//  - Any glitch shorter than CNT_MAX cycles (post-sync) produces no output change.
//  - o_pos and o_neg are never both high on one channel; each is 1 cycle wide.
//  - Channels are fully independent; simultaneous events on several channels are each reported
//    in the same cycle.
//  - CNT_MAX=1: change accepted on first mismatching cycle (pure synchroniser + edge detect).
//  - Reset mid-filter or mid-hold: all state returns to reset values; no pulse is emitted on
//    release from reset.
// CONFIGURATION
//  Macro KEY_DEBOUNCE_REPEAT_EN.
//  Defined: per channel, rep_cnt starts at the press pulse (o_level entering ~IDLE_LEVEL).
//    First o_repeat fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD
//    cycles while o_level stays active.
//    Release (o_level back to IDLE_LEVEL) clears rep_cnt immediately; no repeat in the release
//    cycle or after it.
//    The press pulse itself is never accompanied by o_repeat.
//  Undefined: no repeat logic synthesised; o_repeat tied to '0; REPEAT_* parameters ignored.
// STRUCTURE
//  Package key_debounce_pkg:
//    default constants (CNT_10MS_50MHZ, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF).
//    typedef struct packed {logic level, pos, neg, repeat_p;} key_evt_t.
//  Sub-module key_debounce_ch: one channel (sync + filter + optional repeat).
//  Top instantiates N_CH copies in a generate loop; no shared state between channels.
// TESTING  (bench params: CNT_MAX=4, IDLE_LEVEL=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset then hold i_in=4'hF 20 cycles -> o_level=4'hF; o_pos/o_neg/o_repeat stay 0.
//  2 ch0 drops to 0 at edge k and stays low -> o_level[0]=0 and o_neg[0]=1 for exactly one cycle,
//    both at edge k+5.
//  3 ch1 pulses low for 3 cycles (bounce) -> no change on o_level[1]; o_neg[1] never asserts.
//  4 ch0 and ch2 drop in the same cycle -> o_neg=4'b0101 in a single cycle.
//  5 REPEAT_EN, ch3 held low 25 cycles after press pulse at edge p -> o_repeat[3] at p+10, p+13,
//    p+16, p+19, p+22, p+25; release -> no further repeats; o_pos[3] 5 cycles later.
//  6 i_rst_n asserted with ch0 mid-count (cnt=2) -> outputs reset immediately; after release with
//    i_in=4'hF, no pulses are emitted.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared constants and the per-channel event record for the key debouncer array.
// The auto-repeat feature is selected by the KEY_DEBOUNCE_REPEAT_EN macro in key_debounce_ch.
package key_debounce_pkg;

  localparam int unsigned CNT_10MS_50MHZ    = 500_000;
  localparam int unsigned REPEAT_DELAY_DEF  = 25_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;

  typedef struct packed {
    logic level;
    logic pos;
    logic neg;
    logic repeat_p;
  } key_evt_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, mismatch-count filter, edge pulses and,
// when KEY_DEBOUNCE_REPEAT_EN is defined, an auto-repeat pulse while held active.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX       = CNT_10MS_50MHZ,
  parameter logic        IDLE_LEVEL    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_in,
  output key_evt_t o_evt
);

  localparam int unsigned    CW        = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic           ACTIVE    = ~IDLE_LEVEL;
  localparam bit             REP_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pos_q, pos_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= i_in;
      sync2_q <= sync1_q;
    end
  end

  // A change is accepted only after CNT_MAX consecutive mismatching samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      pos_d   = sync2_q;
      neg_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= IDLE_LEVEL;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RW-1:0] rep_target;
  logic          armed_q, armed_d;
  logic          rep_q, rep_d;

  assign rep_target = armed_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);

  // Counting only runs while the level is active both now and next cycle, so the
  // press cycle and the release cycle never carry a repeat pulse.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    armed_d   = armed_q;
    rep_d     = 1'b0;
    if ((level_q == ACTIVE) && (level_d == ACTIVE)) begin
      if (REP_CFG_OK && (rep_cnt_q + RW'(1) == rep_target)) begin
        rep_d     = 1'b1;
        rep_cnt_d = '0;
        armed_d   = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_cnt_d = '0;
      armed_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rep_cnt_q <= '0;
      armed_q   <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      armed_q   <= armed_d;
      rep_q     <= rep_d;
    end
  end

  assign rep_pulse = rep_q;
`else
  // No repeat hardware in this build; the configuration check folds to a constant zero.
  assign rep_pulse = 1'b0 & REP_CFG_OK;
`endif

  assign o_evt.level    = level_q;
  assign o_evt.pos      = pos_q;
  assign o_evt.neg      = neg_q;
  assign o_evt.repeat_p = rep_pulse;

endmodule

// File: rtl/key_debounce_array.sv
// N_CH independent debounce channels between board pins and control logic.
// Auto-repeat outputs are live only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_array
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned CNT_MAX       = CNT_10MS_50MHZ,
  parameter logic        IDLE_LEVEL    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_repeat
);

  key_evt_t evt [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX      (CNT_MAX),
      .IDLE_LEVEL   (IDLE_LEVEL),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_in   (i_in[g]),
      .o_evt  (evt[g])
    );

    assign o_level[g]  = evt[g].level;
    assign o_pos[g]    = evt[g].pos;
    assign o_neg[g]    = evt[g].neg;
    assign o_repeat[g] = evt[g].repeat_p;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array with an event scoreboard keyed by cycle number.
// Repeat expectations are only scheduled when KEY_DEBOUNCE_REPEAT_EN is defined.
module tb_key_debounce_array;

  localparam int unsigned N_CH          = 4;
  localparam int unsigned CNT_MAX       = 4;
  localparam int unsigned REPEAT_DELAY  = 10;
  localparam int unsigned REPEAT_PERIOD = 3;
  localparam int          LAT           = 1 + CNT_MAX;
  localparam logic [1:0]  K_POS = 2'd0, K_NEG = 2'd1, K_REP = 2'd2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] in_v;
  logic [N_CH-1:0] level, pos, neg, rep;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // entry = {cycle[31:0], kind[1:0], channel vector[3:0]}
  logic [37:0]     exp_q[$];
  logic [3:0]      exp_level = 4'hF;
  logic [37:0]     mon_e;
  logic [3:0]      mon_ep, mon_en, mon_er;

  key_debounce_array #(
    .N_CH         (N_CH),
    .CNT_MAX      (CNT_MAX),
    .IDLE_LEVEL   (1'b1),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_in    (in_v),
    .o_level (level),
    .o_pos   (pos),
    .o_neg   (neg),
    .o_repeat(rep)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] v, output int k);
    @(negedge clk);
    in_v = v;
    k    = cyc + 1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [1:0] kind, input logic [3:0] vec);
    int i;
    logic [31:0] cu;
    i  = 0;
    cu = c;
    while (i < exp_q.size() && exp_q[i][37:6] <= cu) i++;
    exp_q.insert(i, {cu, kind, vec});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    mon_ep = '0;
    mon_en = '0;
    mon_er = '0;
    while (exp_q.size() > 0 && int'(exp_q[0][37:6]) <= cyc) begin
      mon_e = exp_q.pop_front();
      if (int'(mon_e[37:6]) < cyc) begin
        checks++;
        errors++;
        $error("FAIL stale_exp cyc=%0d expected event at %0d never matched", cyc, mon_e[37:6]);
      end else begin
        case (mon_e[5:4])
          K_POS:   mon_ep = mon_ep | mon_e[3:0];
          K_NEG:   mon_en = mon_en | mon_e[3:0];
          default: mon_er = mon_er | mon_e[3:0];
        endcase
      end
    end
    if (!rst_n) exp_level = 4'hF;
    else        exp_level = (exp_level | mon_ep) & ~mon_en;

    checks++;
    assert (pos === mon_ep) else begin
      errors++;
      $error("FAIL o_pos cyc=%0d observed=%b expected=%b", cyc, pos, mon_ep);
    end
    checks++;
    assert (neg === mon_en) else begin
      errors++;
      $error("FAIL o_neg cyc=%0d observed=%b expected=%b", cyc, neg, mon_en);
    end
    checks++;
    assert (rep === mon_er) else begin
      errors++;
      $error("FAIL o_repeat cyc=%0d observed=%b expected=%b", cyc, rep, mon_er);
    end
    checks++;
    assert (level === exp_level) else begin
      errors++;
      $error("FAIL o_level cyc=%0d observed=%b expected=%b", cyc, level, exp_level);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int k, k2, p, r;
    rst_n = 1'b0;
    in_v  = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    assert (level === 4'hF && pos === 4'h0 && neg === 4'h0 && rep === 4'h0) else begin
      errors++;
      $error("FAIL reset_state observed=%b/%b/%b/%b expected=1111/0000/0000/0000",
             level, pos, neg, rep);
    end
    rst_n = 1'b1;

    // 1: idle hold
    repeat (20) @(negedge clk);
    checks++;
    assert (level === 4'hF) else begin
      errors++;
      $error("FAIL idle_level observed=%b expected=1111", level);
    end

    // 2: single fall on ch0, exact latency
    drive(4'hE, k);
    push_exp(k + LAT, K_NEG, 4'b0001);
    wait_until(k + LAT - 1);
    checks++;
    assert (level[0] === 1'b1) else begin
      errors++;
      $error("FAIL ch0_before_latency observed=%b expected=1", level[0]);
    end
    wait_until(k + LAT);
    checks++;
    assert (level[0] === 1'b0) else begin
      errors++;
      $error("FAIL ch0_at_latency observed=%b expected=0", level[0]);
    end
    drive(4'hF, k2);
    push_exp(k2 + LAT, K_POS, 4'b0001);
    wait_until(k2 + LAT + 3);

    // 3: 3-cycle bounce on ch1 is rejected
    drive(4'hD, k);
    repeat (2) @(negedge clk);
    drive(4'hF, k2);
    wait_until(k2 + 10);
    checks++;
    assert (level === 4'hF) else begin
      errors++;
      $error("FAIL bounce_level observed=%b expected=1111", level);
    end

    // 4: ch0 and ch2 fall together, then rise together
    drive(4'hA, k);
    push_exp(k + LAT, K_NEG, 4'b0101);
    wait_until(k + LAT + 1);
    drive(4'hF, k2);
    push_exp(k2 + LAT, K_POS, 4'b0101);
    wait_until(k2 + LAT + 3);

    // 5: long hold on ch3 (repeat train when enabled), release before the next repeat slot
    drive(4'h7, k);
    p = k + LAT;
    push_exp(p, K_NEG, 4'b1000);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    for (int t = int'(REPEAT_DELAY); t <= 25; t += int'(REPEAT_PERIOD))
      push_exp(p + t, K_REP, 4'b1000);
`endif
    wait_until(p + 21);
    drive(4'hF, r);
    push_exp(r + LAT, K_POS, 4'b1000);
    wait_until(r + LAT + 10);

    // 6: reset with ch0 mid-count
    drive(4'hE, k);
    wait_until(k + 3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert (level === 4'hF && pos === 4'h0 && neg === 4'h0 && rep === 4'h0) else begin
      errors++;
      $error("FAIL async_reset observed=%b/%b/%b/%b expected=1111/0000/0000/0000",
             level, pos, neg, rep);
    end
    in_v = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    assert (level === 4'hF) else begin
      errors++;
      $error("FAIL post_reset_level observed=%b expected=1111", level);
    end

    // ---------------- final report ----------------
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL pending_exp observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
